// File: rtl/single_port_lutram.sv
// single_port_lutram
// Small single-port memory (tag/data/metadata store) built from LUT RAM or flops.
// One shared address per cycle serves either a write or a read. Writes are
// synchronous, read data is registered (1-cycle latency), and a write also
// drives the written value onto the read port (write-first). Reset clears the
// whole array and the read register so nothing downstream ever sees X.
//
// Access qualification: access_en_in = 1 means an access happens at this
// rising edge; write_en_in picks write (1) or read (0). With access_en_in = 0
// the address, write_en_in and data are ignored and the read register holds.
// There is no back-pressure: every enabled cycle is accepted, so reads and
// writes can run back to back with no bubbles.
module single_port_lutram #(
  parameter int SINGLE_ELEMENT_SIZE_IN_BITS = 64,
  parameter int NUMBER_SETS                 = 64,
  parameter int SET_PTR_WIDTH_IN_BITS       = $clog2(NUMBER_SETS)
) (
  input  logic                                   clk_in,
  input  logic                                   reset_in,
  input  logic                                   access_en_in,
  input  logic                                   write_en_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]       access_set_addr_in,
  input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] write_element_in,
  output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] read_element_out
);

  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] mem_q [NUMBER_SETS];
  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] rd_q;
  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] rd_d;
  logic                                   mem_we;
  logic                                   in_range;

  // Address range check: only needed when the depth is not a power of two,
  // otherwise every encodable address is a real entry.
  generate
    if ((1 << SET_PTR_WIDTH_IN_BITS) == NUMBER_SETS) begin : g_pow2
      assign in_range = 1'b1;
    end else begin : g_npow2
      assign in_range = (32'(access_set_addr_in) < 32'(NUMBER_SETS));
    end
  endgenerate

  // Decode the access: write enable for the array and next read-register value.
  // Out-of-range writes are dropped (read register holds); out-of-range reads return 0.
  always_comb begin
    rd_d   = rd_q;
    mem_we = 1'b0;
    if (access_en_in) begin
      if (in_range) begin
        if (write_en_in) begin
          mem_we = 1'b1;
          rd_d   = write_element_in;
        end else begin
          rd_d = mem_q[access_set_addr_in];
        end
      end else if (!write_en_in) begin
        rd_d = '0;
      end
    end
  end

  // Array and read register update; reset wins over any access in the same cycle.
  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      for (int i = 0; i < NUMBER_SETS; i++) begin
        mem_q[i] <= '0;
      end
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
      if (mem_we) begin
        mem_q[access_set_addr_in] <= write_element_in;
      end
    end
  end

  assign read_element_out = rd_q;

endmodule

// File: tb/tb_single_port_lutram.sv
// Bench for single_port_lutram: a 64-entry and a 48-entry instance share one
// stimulus stream and are compared against array-based reference models.
module tb_single_port_lutram;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        we;
  logic [5:0]  addr;
  logic [63:0] wdata;
  logic [63:0] rd64;
  logic [63:0] rd48;

  int total = 0;
  int bad   = 0;

  // Reference state: plain arrays plus the expected read-port value.
  logic [63:0] m64 [64];
  logic [63:0] m48 [48];
  logic [63:0] exp64;
  logic [63:0] exp48;

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  single_port_lutram #(
    .SINGLE_ELEMENT_SIZE_IN_BITS(64),
    .NUMBER_SETS(64)
  ) dut64 (
    .clk_in             (clk),
    .reset_in           (rst_n),
    .access_en_in       (en),
    .write_en_in        (we),
    .access_set_addr_in (addr),
    .write_element_in   (wdata),
    .read_element_out   (rd64)
  );

  single_port_lutram #(
    .SINGLE_ELEMENT_SIZE_IN_BITS(64),
    .NUMBER_SETS(48)
  ) dut48 (
    .clk_in             (clk),
    .reset_in           (rst_n),
    .access_en_in       (en),
    .write_en_in        (we),
    .access_set_addr_in (addr),
    .write_element_in   (wdata),
    .read_element_out   (rd48)
  );

  // Reference behaviour for one rising edge, written from the memory's rules.
  task automatic model_edge(input logic r, input logic e, input logic w,
                            input int a, input logic [63:0] d);
    if (!r) begin
      for (int i = 0; i < 64; i++) m64[i] = '0;
      for (int i = 0; i < 48; i++) m48[i] = '0;
      exp64 = '0;
      exp48 = '0;
    end else if (e) begin
      if (w) begin
        m64[a] = d;
        exp64  = d;
      end else begin
        exp64 = m64[a];
      end
      if (a < 48) begin
        if (w) begin
          m48[a] = d;
          exp48  = d;
        end else begin
          exp48 = m48[a];
        end
      end else if (!w) begin
        exp48 = '0;
      end
    end
  endtask

  // Driver: apply one cycle of stimulus, advance the model, check both outputs.
  task automatic step(input logic r, input logic e, input logic w,
                      input int a, input logic [63:0] d, input string tag);
    @(negedge clk);
    rst_n = r;
    en    = e;
    we    = w;
    addr  = 6'(a);
    wdata = d;
    @(posedge clk);
    #1;
    model_edge(r, e, w, a, d);
    total++;
    assert (rd64 === exp64) else begin
      bad++;
      $error("FAIL %s n64 addr=%0d observed=%h expected=%h", tag, a, rd64, exp64);
    end
    total++;
    assert (rd48 === exp48) else begin
      bad++;
      $error("FAIL %s n48 addr=%0d observed=%h expected=%h", tag, a, rd48, exp48);
    end
  endtask

  task automatic rd(input int a, input string tag);
    step(1'b1, 1'b1, 1'b0, a, {$urandom, $urandom}, tag);
  endtask

  task automatic wr(input int a, input logic [63:0] d, input string tag);
    step(1'b1, 1'b1, 1'b1, a, d, tag);
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    we    = 1'b0;
    addr  = '0;
    wdata = '0;
    exp64 = 'x;
    exp48 = 'x;

    // reset held 5 cycles, access presented meanwhile must be dropped
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, i, 64'hA5A5_A5A5_A5A5_A5A5, "reset");

    // read everything after reset
    for (int i = 0; i < 64; i++) rd(i, "post_reset_read");

    // fill (write-through checked each cycle) and read back
    for (int i = 0; i < 64; i++) wr(i, 64'h0123_4567_0000_0000 + 64'(i), "fill_wt");
    for (int i = 0; i < 64; i++) rd(i, "fill_read");

    // write/read interleave
    for (int i = 0; i < 10; i++) begin
      wr(i, 64'hDEAD_BEEF_0000_0000 | (64'(i) << 4), "ilv_write");
      rd(i, "ilv_read");
    end
    for (int i = 0; i < 64; i++) rd(i, "ilv_others");

    // idle hold with toggling don't-care inputs
    rd(5, "idle_pre");
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 63),
           {$urandom, $urandom}, "idle_hold");
    for (int i = 0; i < 64; i++) rd(i, "idle_mem");

    // reset in the same cycle as a write to address 3
    for (int i = 0; i < 64; i++) wr(i, {$urandom, $urandom} | 64'h1, "pre_reset_fill");
    step(1'b0, 1'b1, 1'b1, 3, 64'hFFFF_FFFF_FFFF_FFFF, "mid_reset");
    for (int i = 0; i < 64; i++) rd(i, "mid_reset_read");

    // non-power-of-two boundary (48-entry instance): 50 out of range, 47 valid
    wr(50, 64'h5050_5050_5050_5050, "oor_write");
    rd(50, "oor_read");
    wr(47, 64'h4747_4747_4747_4747, "last_write");
    rd(47, "last_read");
    rd(50, "oor_read2");
    rd(47, "last_read2");

    // randomized mix: reads, writes, idles, occasional reset
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), $urandom_range(0, 63),
           {$urandom, $urandom}, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "time limit reached");
  end

endmodule

// File: doc/single_port_lutram.md
Name: single_port_lutram

Overview:
- Parameterised single-port memory of NUMBER_SETS entries, each SINGLE_ELEMENT_SIZE_IN_BITS wide, built from distributed (LUT) RAM or flops.
- One shared address serves either a write or a read per cycle.
- Used as a small tag/data/metadata store inside cache and pipeline structures.
- Synchronous write, registered read data, full-array clear on reset.

Parameters:
- SINGLE_ELEMENT_SIZE_IN_BITS, 64, width of one stored element.
- NUMBER_SETS, 64, number of entries; any value >= 2, not required to be a power of two.
- SET_PTR_WIDTH_IN_BITS, $clog2(NUMBER_SETS), address width.

Ports:
- clk_in  input  1  clock; all state changes on rising edge.
- reset_in  input  1  reset, synchronous, active-low.
- access_en_in  input  1  qualifies the access this cycle.
- write_en_in  input  1  1 = write, 0 = read; ignored unless access_en_in = 1.
- access_set_addr_in  input  SET_PTR_WIDTH_IN_BITS  entry index.
- write_element_in  input  SINGLE_ELEMENT_SIZE_IN_BITS  write data.
- read_element_out  output  SINGLE_ELEMENT_SIZE_IN_BITS  registered read data.

Behaviour:
- Reset (reset_in = 0 at a rising edge):
  - All NUMBER_SETS entries are cleared to 0 in that same cycle.
  - read_element_out is cleared to 0.
  - Reset has priority over any access presented in the same cycle; that access is dropped.
  - A reset asserted mid-sequence discards all stored contents.
- Write (access_en_in = 1, write_en_in = 1, address < NUMBER_SETS):
  - At the rising edge, mem[addr] <= write_element_in.
  - read_element_out <= write_element_in (write-first / write-through), so the written value is visible one cycle later.
- Read (access_en_in = 1, write_en_in = 0, address < NUMBER_SETS):
  - At the rising edge, read_element_out <= mem[addr].
  - Latency is 1 cycle from the address edge to valid data.
- Idle (access_en_in = 0):
  - No memory change; read_element_out holds its previous value.
  - write_en_in, address and data are don't-care.
- Out-of-range address (>= NUMBER_SETS; possible only when NUMBER_SETS is not a power of two):
  - Writes are ignored and memory is unchanged.
  - Reads load 0 into read_element_out.
- Back-to-back accesses:
  - Any mix of reads and writes on consecutive cycles runs at full throughput, with no bubbles.
  - A read of an address written in the previous cycle returns the new data.
- No X propagation: after reset, every entry and the output are defined.

Test Plan:
- Reset then read all: hold reset_in = 0 for 5 cycles, release, then read addresses 0..63 with access_en_in = 1, write_en_in = 0 -> read_element_out = 0 for every address, each one cycle after its address edge.
- Fill and read back: write mem[i] = 64'h0123_4567_0000_0000 + i for i = 0..63 on consecutive cycles, then read 0..63 -> each read returns the matching value one cycle later. Also check that read_element_out equals the written data one cycle after each write (write-through).
- Write/read interleave: for i = 0..9, write 64'hDEAD_BEEF_0000_00i0 to address i, then read address i on the next cycle -> read_element_out equals the written value; no other entry changes.
- Idle hold: after a read of address 5 returns X5, drive access_en_in = 0 and toggle the address, write_en_in and data for 4 cycles -> read_element_out stays X5, and a subsequent read of the toggled addresses shows memory unchanged.
- Reset mid-operation: fill entries with non-zero data, then assert reset_in = 0 in the same cycle as a write of 64'hFFFF_FFFF_FFFF_FFFF to address 3 -> after release, all reads (including address 3) return 0 and read_element_out = 0 immediately after reset.
- Non-power-of-two configuration (NUMBER_SETS = 48): write to address 50 and read address 50 -> memory unchanged and read returns 0; address 47 behaves normally.
